// File: rtl/locked_fsm_key_seq.sv
// locked_fsm_key_seq: serial key loader and reset/run sequencer for a key-locked FSM core.
// The key arrives LSB-first on key_bit/key_valid and is driven in parallel on key_out
// once complete. The core is held in reset for ARM_CYC cycles with a stable key, then
// released and its run cycles counted. All state changes on the falling clock edge.
// Optional build macro KEY_PARITY_EN adds an even-parity bit after the key, plus the
// PAR (check) and ERR (latched parity failure) states.
`timescale 1ns/1ps

module locked_fsm_key_seq #(
  parameter int KEY_W   = 8,
  parameter int ARM_CYC = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  input  logic             reload,
  output logic [KEY_W-1:0] key_out,
  output logic             core_rst,
  output logic             core_en,
  output logic [CNT_W-1:0] run_cnt,
  output logic             busy,
  output logic             key_err
);

  localparam int BC_W  = $clog2(KEY_W + 1);
  localparam int ARM_W = $clog2(ARM_CYC + 1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_PAR   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;

  // State and datapath registers, falling-edge clocked, reset asynchronously.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      bit_cnt_q <= '0;
      key_q     <= '0;
      arm_cnt_q <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      key_q     <= key_d;
      arm_cnt_q <= arm_cnt_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Next-state logic; reload always wins over bit acceptance and the ARM->RUN step.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    key_d     = key_q;
    arm_cnt_d = arm_cnt_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      S_LOAD: begin
        if (reload) begin
          bit_cnt_d = '0;
          key_d     = '0;
        end else if (key_valid) begin
          // Write the incoming bit into the slot selected by bit_cnt.
          for (int i = 0; i < KEY_W; i++) begin
            if (bit_cnt_q == BC_W'(i)) begin
              key_d[i] = key_bit;
            end
          end
          if (bit_cnt_q == BC_W'(KEY_W - 1)) begin
            bit_cnt_d = '0;
`ifdef KEY_PARITY_EN
            state_d   = S_PAR;
`else
            state_d   = S_ARM;
            arm_cnt_d = '0;
            run_cnt_d = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
`ifdef KEY_PARITY_EN
      S_PAR: begin
        if (reload) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          key_d     = '0;
        end else if (key_valid) begin
          // Even parity: the extra bit must equal the XOR of all key bits.
          if (key_bit == ^key_q) begin
            state_d   = S_ARM;
            arm_cnt_d = '0;
            run_cnt_d = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        if (reload) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          key_d     = '0;
        end
      end
`endif
      S_ARM: begin
        if (reload) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          key_d     = '0;
          arm_cnt_d = '0;
        end else if (arm_cnt_q == ARM_W'(ARM_CYC - 1)) begin
          state_d   = S_RUN;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      S_RUN: begin
        if (reload) begin
          // Clear on the way into FLUSH so the flush cycle already shows zeros.
          state_d   = S_FLUSH;
          key_d     = '0;
          run_cnt_d = '0;
        end else if (run_cnt_q != {CNT_W{1'b1}}) begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        state_d   = S_LOAD;
        bit_cnt_d = '0;
        key_d     = '0;
        run_cnt_d = '0;
      end
      default: begin
        state_d   = S_LOAD;
        bit_cnt_d = '0;
        key_d     = '0;
        arm_cnt_d = '0;
        run_cnt_d = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state; key_ready also looks at reload.
  always_comb begin
    key_out  = (state_q == S_ARM || state_q == S_RUN) ? key_q : '0;
    core_rst = (state_q != S_RUN);
    core_en  = (state_q == S_RUN);
    busy     = (state_q != S_RUN);
    run_cnt  = run_cnt_q;
`ifdef KEY_PARITY_EN
    key_ready = (state_q == S_LOAD || state_q == S_PAR) && !reload;
    key_err   = (state_q == S_ERR);
`else
    key_ready = (state_q == S_LOAD) && !reload;
    key_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_locked_fsm_key_seq.sv
// Testbench for locked_fsm_key_seq: randomized key loads with gaps, partial-load reloads,
// ARM aborts and run lengths; a monitor checks each RUN episode against a queued expectation.
`timescale 1ns/1ps

module tb_locked_fsm_key_seq;

  localparam int KEY_W   = 8;
  localparam int ARM_CYC = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_valid;
  logic             key_bit;
  logic             key_ready;
  logic             reload;
  logic [KEY_W-1:0] key_out;
  logic             core_rst;
  logic             core_en;
  logic [CNT_W-1:0] run_cnt;
  logic             busy;
  logic             key_err;

  locked_fsm_key_seq #(.KEY_W(KEY_W), .ARM_CYC(ARM_CYC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_bit   (key_bit),
    .key_ready (key_ready),
    .reload    (reload),
    .key_out   (key_out),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .run_cnt   (run_cnt),
    .busy      (busy),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  // One expected RUN episode: which key the core must see and how many RUN cycles.
  typedef struct {
    logic [KEY_W-1:0] key;
    int               run_len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance to just after the next active (falling) edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    key_valid = 1'b0;
    repeat (gap) tick();
    key_valid = 1'b1;
    key_bit   = b;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_key(input logic [KEY_W-1:0] key, input int gap);
    for (int i = 0; i < KEY_W; i++) send_bit(key[i], gap);
`ifdef KEY_PARITY_EN
    send_bit(^key, gap);
`endif
  endtask

  // reload with a simultaneous valid bit: the bit must be ignored.
  task automatic pulse_reload();
    reload    = 1'b1;
    key_valid = 1'b1;
    key_bit   = 1'b1;
    tick();
    reload    = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (core_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One transaction: optional discarded partial load, optional ARM abort, final load,
  // RUN for run_len cycles, then reload into FLUSH.
  task automatic do_txn(input logic [KEY_W-1:0] key, input int gap, input int partial,
                        input bit arm_abort, input int run_len);
    bit ok;
    if (partial > 0) begin
      for (int i = 0; i < partial; i++) send_bit(1'($urandom_range(0, 1)), gap);
      pulse_reload();
    end
    exp_q.push_back('{key: key, run_len: run_len});
    if (arm_abort) begin
      send_key(key, gap);
      pulse_reload();
    end
    send_key(key, gap);
    wait_run(ok);
    chk("run_reached", 32'(ok), 32'd1);
    if (ok) begin
      repeat (run_len - 1) @(negedge clk);
      #1;
      pulse_reload();
    end
    repeat (3) tick();
    $display("txn key=%02h gap=%0d partial=%0d arm_abort=%0d run_len=%0d checks=%0d errors=%0d",
             key, gap, partial, arm_abort, run_len, checks, errors);
  endtask

  // Monitor: tracks the ARM window, checks each RUN episode and the FLUSH that ends it.
  int               arm_seen  = 0;
  int               run_seen  = 0;
  logic [KEY_W-1:0] arm_key   = '0;
  bit               prev_en   = 1'b0;
  bit               prev_flush = 1'b0;
  exp_t             cur       = '{key: '0, run_len: 0};

  always @(posedge clk) begin
    if (mon_en) begin
      if (prev_flush) begin
        chk("ready_after_flush", 32'(key_ready), 32'd1);
        prev_flush = 1'b0;
      end
      if (core_en) begin
        if (!prev_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_run", 32'(exp_q.size()), 32'd1);
          end else begin
            cur = exp_q.pop_front();
            chk("key_out", 32'(key_out), 32'(cur.key));
            chk("arm_cycles", 32'(arm_seen), 32'(ARM_CYC));
          end
          run_seen = 0;
        end
        chk("run_cnt", 32'(run_cnt), 32'((run_seen > CNT_MAX) ? CNT_MAX : run_seen));
        chk("run_core_rst", 32'(core_rst), 32'd0);
        run_seen++;
      end else begin
        if (prev_en) begin
          chk("run_len", 32'(run_seen), 32'(cur.run_len));
          chk("flush_run_cnt", 32'(run_cnt), 32'd0);
          chk("flush_key_out", 32'(key_out), 32'd0);
          chk("flush_core_rst", 32'(core_rst), 32'd1);
          chk("flush_ready", 32'(key_ready), 32'd0);
          prev_flush = 1'b1;
        end
        chk("busy", 32'(busy), 32'd1);
        if (core_rst && key_out != '0) begin
          if (arm_seen > 0 && key_out != arm_key) arm_seen = 1;
          else arm_seen++;
          arm_key = key_out;
        end else begin
          arm_seen = 0;
        end
      end
      chk("key_err", 32'(key_err), 32'd0);
      prev_en = core_en;
    end
  end

  initial begin
    bit ok;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    reload    = 1'b0;
    #2;
    chk("rst_key_out", 32'(key_out), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_run_cnt", 32'(run_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_key_err", 32'(key_err), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    chk("ready_after_rst", 32'(key_ready), 32'd1);
    mon_en = 1'b1;

    do_txn(8'hA5, 0, 0, 1'b0, 12);
    do_txn(8'h3C, 1, 0, 1'b0, 8);
    do_txn(8'hF0, 0, 3, 1'b0, 6);
    do_txn(8'h69, 0, 0, 1'b1, 11);
    do_txn(8'h81, 0, 0, 1'b0, 20);
    for (int t = 0; t < 8; t++) begin
      do_txn(8'($urandom_range(1, 255)), $urandom_range(0, 2),
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, KEY_W - 1) : 0,
             1'($urandom_range(0, 1)), $urandom_range(1, 25));
    end
    repeat (5) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Asynchronous reset in the middle of RUN: outputs must drop without a clock edge.
    send_key(8'h5A, 0);
    wait_run(ok);
    chk("pre_rst_run", 32'(ok), 32'd1);
    repeat (3) @(posedge clk);
    chk("pre_rst_en", 32'(core_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_core_rst", 32'(core_rst), 32'd1);
    chk("async_key_out", 32'(key_out), 32'd0);
    chk("async_core_en", 32'(core_en), 32'd0);
    chk("async_run_cnt", 32'(run_cnt), 32'd0);
    $display("txn async reset mid-RUN checks=%0d errors=%0d", checks, errors);
    @(negedge clk);
    #1;
    rst = 1'b0;

`ifdef KEY_PARITY_EN
    // Bad parity latches ERR until reload; a correct resend reaches RUN.
    for (int i = 0; i < KEY_W; i++) send_bit(1'((8'hA5 >> i) & 1), 0);
    send_bit(1'b1, 0);
    repeat (3) tick();
    chk("par_err", 32'(key_err), 32'd1);
    chk("par_core_en", 32'(core_en), 32'd0);
    chk("par_ready", 32'(key_ready), 32'd0);
    pulse_reload();
    chk("par_err_clear", 32'(key_err), 32'd0);
    send_key(8'hA5, 0);
    wait_run(ok);
    chk("par_run", 32'(ok), 32'd1);
    $display("txn parity error/recover checks=%0d errors=%0d", checks, errors);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
